serial_adder_ctrl: RTL

//   Bit-serial adder controller: sequences one full_adder instance over WIDTH cycles.

---
 rtl/serial_adder_ctrl_if.sv | 24 ++
 rtl/serial_adder_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Start/busy/done handshake plus operand and result bus of the bit-serial adder.
// The master issues operations; the slave is the adder controller.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, op_a, op_b, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, op_a, op_b, carry_in,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder iterated over WIDTH cycles, LSB first,
// with a start/busy/done handshake and results held until the next completion.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_next;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a         (sh_a[0]),
    .b         (sh_b[0]),
    .carry_in  (carry_q),
    .sum       (fa_sum),
    .carry_out (fa_cout)
  );

  // Sum bits enter at the MSB so after WIDTH shifts the LSB sits at bit 0.
  assign sum_sh_next = (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a    <= '0;
      sh_b    <= '0;
      sum_sh  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_a    <= bus.op_a;
            sh_b    <= bus.op_b;
            sum_sh  <= '0;
            carry_q <= bus.carry_in;
            cnt     <= '0;
          end
        end
        RUN: begin
          sh_a    <= sh_a >> 1;
          sh_b    <= sh_b >> 1;
          sum_sh  <= sum_sh_next;
          carry_q <= fa_cout;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum_q  <= sum_sh_next;
            cout_q <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
endmodule
